demux_router: RTL

Parametrised, registered 1:N demultiplexer: the successor to the team's combinational 1:2 demux. It routes a WIDTH-bit word to one of N_OUT output channels chosen by a binary select. Each transfer uses a valid/ready handshake through a single output holding register. It sits between the challenge/stimulus source and the parallel PUF delay-path or arbiter banks, where back-pressure and per-channel delivery tracking are required.

---
 rtl/demux_pkg.sv | 18 +
 rtl/demux_router_if.sv | 37 +++
 rtl/demux_sel_decode.sv | 27 ++
 rtl/demux_router.sv | 132 +++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared constants and types for the demux_router block.
//   CNT_W   : width of each per-channel delivery counter
//   CNT_MAX : saturation value of the delivery counters
//   state_t : holding-register state (EMPTY / FULL)
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/demux_router_if.sv
// -----------------------------------------------------------------------------
// demux_router_if
// Bundles the input handshake, the N_OUT output channels, the sticky select
// error flag and the per-channel delivery counters of demux_router.
//   master : the environment (drives in_*, out_ready)
//   slave  : the demux_router itself
// Channel k of out_data occupies bits [k*WIDTH +: WIDTH]; channel k of
// cnt_out occupies bits [k*CNT_W +: CNT_W].
// -----------------------------------------------------------------------------
interface demux_router_if #(
  parameter int WIDTH = 1,
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT)
);
  import demux_pkg::*;

  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;
  logic                   err_sel;
  logic [N_OUT*CNT_W-1:0] cnt_out;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, err_sel, cnt_out
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, err_sel, cnt_out
  );

endinterface

// File: rtl/demux_sel_decode.sv
// -----------------------------------------------------------------------------
// demux_sel_decode
// Turns the held select into a one-hot channel vector, all zero while the
// holding register is empty.
//   i_sel    : held channel index
//   i_full   : holding register contains a word
//   o_onehot : one bit per channel, at most one set
// -----------------------------------------------------------------------------
module demux_sel_decode #(
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_full,
  output logic [N_OUT-1:0] o_onehot
);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // that no path leaves it unassigned and a latch is never inferred.
    o_onehot = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (i_full && (i_sel == SEL_W'(k))) o_onehot[k] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_router.sv
// -----------------------------------------------------------------------------
// demux_router
// Registered 1:N demultiplexer with a valid/ready handshake through a single
// holding register. A word accepted with an in-range select is presented on
// its channel the following cycle; an out-of-range select drops the word and
// sets the sticky err_sel flag.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : demux_router_if.slave (in_*, out_*, err_sel, cnt_out)
// Build option: define DEMUX_COUNT_EN for saturating 16-bit per-channel
// delivery counters on cnt_out; otherwise cnt_out is tied to zero.
// -----------------------------------------------------------------------------
module demux_router
  import demux_pkg::*;
#(
  parameter  int WIDTH = 1,
  parameter  int N_OUT = 4,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic           clk,
  input  logic           rst_n,
  demux_router_if.slave  bus
);

  // N_OUT needs one extra bit when it is a power of two.
  localparam logic [SEL_W:0] N_OUT_V = (SEL_W + 1)'(N_OUT);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_hold_data;
  logic [SEL_W-1:0] r_hold_sel;
  logic             r_err_sel;
  logic             r_in_ready_en;  // low from a reset edge until rst_n is seen high

  logic [N_OUT-1:0]       w_onehot;
  logic [N_OUT*WIDTH-1:0] w_out_data;
  logic                   w_pop;
  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_sel_ok;
  logic                   w_load;
  logic                   w_err_set;

  demux_sel_decode #(
    .N_OUT (N_OUT),
    .SEL_W (SEL_W)
  ) u_sel_decode (
    .i_sel    (r_hold_sel),
    .i_full   (r_state == FULL),
    .o_onehot (w_onehot)
  );

  // Only the ready of the channel currently holding the word matters.
  assign w_pop      = |(w_onehot & bus.out_ready);
  assign w_in_ready = r_in_ready_en & ((r_state == EMPTY) | w_pop);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_sel_ok   = ({1'b0, bus.in_sel} < N_OUT_V);
  assign w_err_set  = w_accept & ~w_sel_ok;

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept && w_sel_ok) begin
          w_next_state = FULL;
          w_load       = 1'b1;
        end
      end
      FULL: begin
        // Pop and accept together replace the word with no bubble.
        if (w_pop) begin
          if (w_accept && w_sel_ok) w_load       = 1'b1;
          else                      w_next_state = EMPTY;
        end
      end
      default: w_next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state       <= EMPTY;
      r_hold_data   <= '0;
      r_hold_sel    <= '0;
      r_err_sel     <= 1'b0;
      r_in_ready_en <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_in_ready_en <= 1'b1;
      if (w_load) begin
        r_hold_data <= bus.in_data;
        r_hold_sel  <= bus.in_sel;
      end
      if (w_err_set) r_err_sel <= 1'b1;
    end
  end

  always_comb begin
    w_out_data = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (w_onehot[k]) w_out_data[k*WIDTH +: WIDTH] = r_hold_data;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_onehot;
  assign bus.out_data  = w_out_data;
  assign bus.err_sel   = r_err_sel;

`ifdef DEMUX_COUNT_EN
  logic [N_OUT-1:0][CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (w_onehot[k] && bus.out_ready[k] && (r_cnt[k] != CNT_MAX))
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
      end
    end
  end

  assign bus.cnt_out = r_cnt;
`else
  assign bus.cnt_out = '0;
`endif

endmodule
